simon_key_sched: RTL and testbench

Parametrised Simon key-expansion engine: loads an m-word master key, generates the full round-key sequence k[0..ROUNDS-1] for any standard Simon word size, and streams each key out over a valid/ready handshake. A compile-time option also stores every key in an internal buffer with a random-access read port. It sits between the key input register and the Simon round datapath. It supersedes the fixed 32/64 schedule with generalised width, key length and z-sequence, back-pressure, and schedule storage.

---
 rtl/simon_pkg.sv | 39 +++
 rtl/simon_key_sched_if.sv | 15 +
 rtl/simon_ks_step.sv | 28 ++
 rtl/simon_key_sched.sv | 133 +++++++++++++
 tb/tb_simon_key_sched.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// Shared Simon key-schedule definitions: z constant sequences, FSM states
// and the legal-configuration check used at elaboration time.
package simon_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ks_state_t;

    function automatic logic [61:0] rev62(input logic [61:0] v);
        logic [61:0] r;
        for (int t = 0; t < 62; t++) begin
            r[t] = v[61-t];
        end
        return r;
    endfunction

    // Literals are written as published (first digit leftmost) and reversed so bit t = z_j[t].
    localparam logic [61:0] Z_TABLE [5] = '{
        rev62(62'b11111010001001010110000111001101111101000100101011000011100110),
        rev62(62'b10001110111110010011000010110101000111011111001001100001011010),
        rev62(62'b10101111011100000011010010011000101000010001111110010110110011),
        rev62(62'b11011011101011000110010111100000010010001010011100110100001111),
        rev62(62'b11010001111001101011011000100000010111000011001010010011101111)
    };

    function automatic bit simon_cfg_ok(input int w, input int m, input int r, input int z);
        bit pair_ok;
        case (w)
            16:      pair_ok = (m == 4);
            24, 32:  pair_ok = (m == 3) || (m == 4);
            48:      pair_ok = (m == 2) || (m == 3);
            64:      pair_ok = (m >= 2) && (m <= 4);
            default: pair_ok = 1'b0;
        endcase
        return pair_ok && (r >= m + 1) && (r <= 72) && (z >= 0) && (z <= 4);
    endfunction

endpackage

// File: rtl/simon_key_sched_if.sv
// Round-key stream: valid/ready handshake carrying key, index and last flag.
// Master drives the key; slave applies back-pressure through rk_ready.
interface simon_key_sched_if #(
    parameter int WORD_W = 16,
    parameter int IDX_W  = 5
);
    logic              rk_valid;
    logic              rk_ready;
    logic [WORD_W-1:0] round_key;
    logic [IDX_W-1:0]  rk_index;
    logic              rk_last;

    modport master (output rk_valid, round_key, rk_index, rk_last, input rk_ready);
    modport slave  (input rk_valid, round_key, rk_index, rk_last, output rk_ready);
endinterface

// File: rtl/simon_ks_step.sv
// One Simon key-expansion step: k[i] from k[i-1], k[i-3], k[i-m] and z bit.
// Purely combinational, zero latency, no flow control.
module simon_ks_step #(
    parameter int WORD_W    = 16,
    parameter int KEY_WORDS = 4
) (
    input  logic [WORD_W-1:0] i_k_im1,
    input  logic [WORD_W-1:0] i_k_im3,
    input  logic [WORD_W-1:0] i_k_im,
    input  logic              i_z,
    output logic [WORD_W-1:0] o_k
);

    localparam logic [WORD_W-1:0] C_CONST = {{(WORD_W-2){1'b1}}, 2'b00};

    function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x, input int r);
        return (x >> r) | (x << (WORD_W - r));
    endfunction

    logic [WORD_W-1:0] w_tmp;
    logic [WORD_W-1:0] w_k3_term;

    // Only the four-word schedule folds in k[i-3].
    assign w_k3_term = (KEY_WORDS == 4) ? i_k_im3 : '0;
    assign w_tmp     = ror(i_k_im1, 3) ^ w_k3_term;
    assign o_k       = C_CONST ^ {{(WORD_W-1){1'b0}}, i_z} ^ i_k_im ^ w_tmp ^ ror(w_tmp, 1);

endmodule

// File: rtl/simon_key_sched.sv
// Simon key schedule: start loads the master key, k[0] valid next cycle, one key per accepted handshake;
// rk_ready low holds the stream. SIMON_KS_STORE_EN adds a round-key buffer with a 1-cycle read port.
module simon_key_sched
    import simon_pkg::*;
#(
    parameter  int WORD_W    = 16,
    parameter  int KEY_WORDS = 4,
    parameter  int ROUNDS    = 32,
    parameter  int Z_SEQ     = 0,
    localparam int IDX_W     = $clog2(ROUNDS)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [WORD_W*KEY_WORDS-1:0] key,
    simon_key_sched_if.master           rk,
    output logic                        busy,
    output logic                        done,
    input  logic [IDX_W-1:0]            rd_addr,
    output logic [WORD_W-1:0]           rd_data
);

    generate
        if (!simon_cfg_ok(WORD_W, KEY_WORDS, ROUNDS, Z_SEQ)) begin : g_bad_cfg
            $error("simon_key_sched: illegal WORD_W/KEY_WORDS/ROUNDS/Z_SEQ combination");
        end
    endgenerate

    localparam int IM3 = (KEY_WORDS == 4) ? 1 : 0;

    ks_state_t         r_state, w_state_nxt;
    logic              r_done, w_done_nxt;
    logic [WORD_W-1:0] r_k [KEY_WORDS];
    logic [IDX_W-1:0]  r_idx;
    logic [5:0]        r_zidx;
    logic              w_hs;
    logic              w_last;
    logic [WORD_W-1:0] w_k_new;

    assign w_last = (r_idx == IDX_W'(ROUNDS - 1));
    assign w_hs   = (r_state == ST_RUN) && rk.rk_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // start outranks a simultaneous handshake, including one on the last key.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = r_done;
        if (start) begin
            w_state_nxt = ST_RUN;
            w_done_nxt  = 1'b0;
        end else if (w_hs && w_last) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
        end
    end

    // r_k[0] is the key on the bus; r_k[j] holds k[i+j].
    simon_ks_step #(
        .WORD_W   (WORD_W),
        .KEY_WORDS(KEY_WORDS)
    ) u_step (
        .i_k_im1(r_k[KEY_WORDS-1]),
        .i_k_im3(r_k[IM3]),
        .i_k_im (r_k[0]),
        .i_z    (Z_TABLE[Z_SEQ][r_zidx]),
        .o_k    (w_k_new)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < KEY_WORDS; j++) begin
                r_k[j] <= '0;
            end
            r_idx  <= '0;
            r_zidx <= '0;
        end else if (start) begin
            for (int j = 0; j < KEY_WORDS; j++) begin
                r_k[j] <= key[j*WORD_W +: WORD_W];
            end
            r_idx  <= '0;
            r_zidx <= '0;
        end else if (w_hs) begin
            for (int j = 0; j < KEY_WORDS - 1; j++) begin
                r_k[j] <= r_k[j+1];
            end
            r_k[KEY_WORDS-1] <= w_k_new;
            r_idx            <= r_idx + 1'b1;
            r_zidx           <= (r_zidx == 6'd61) ? 6'd0 : r_zidx + 6'd1;
        end
    end

    assign rk.rk_valid  = (r_state == ST_RUN);
    assign rk.round_key = r_k[0];
    assign rk.rk_index  = r_idx;
    assign rk.rk_last   = (r_state == ST_RUN) && w_last;
    assign busy         = (r_state == ST_RUN);
    assign done         = r_done;

`ifdef SIMON_KS_STORE_EN
    logic [WORD_W-1:0] r_buf [ROUNDS];
    logic [WORD_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (w_hs && !start) begin
            r_buf[r_idx] <= r_k[0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_buf[rd_addr];
        end
    end

    assign rd_data = r_rd_data;
`else
    logic w_unused_rd_addr;
    assign w_unused_rd_addr = ^rd_addr;
    assign rd_data          = '0;
`endif

endmodule

// File: tb/tb_simon_key_sched.sv
// Directed bench for simon_key_sched: three configurations (16/4/32/z0, 32/4/44/z3, 24/3/36/z1)
// sharing start and rk_ready; a mux selects which instance the stream checks observe.
module tb_simon_key_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n, start, rk_ready;
    logic [63:0]  key16;
    logic [127:0] key32;
    logic [71:0]  key24;
    logic [4:0]   rd_addr16;
    logic [5:0]   rd_addr32, rd_addr24;
    logic [15:0]  rd_data16;
    logic [31:0]  rd_data32;
    logic [23:0]  rd_data24;
    logic         busy16, done16, busy32, done32, busy24, done24;

    simon_key_sched_if #(.WORD_W(16), .IDX_W(5)) if16 ();
    simon_key_sched_if #(.WORD_W(32), .IDX_W(6)) if32 ();
    simon_key_sched_if #(.WORD_W(24), .IDX_W(6)) if24 ();

    assign if16.rk_ready = rk_ready;
    assign if32.rk_ready = rk_ready;
    assign if24.rk_ready = rk_ready;

    simon_key_sched dut16 (
        .clk(clk), .reset_n(reset_n), .start(start), .key(key16), .rk(if16.master),
        .busy(busy16), .done(done16), .rd_addr(rd_addr16), .rd_data(rd_data16)
    );

    simon_key_sched #(.WORD_W(32), .KEY_WORDS(4), .ROUNDS(44), .Z_SEQ(3)) dut32 (
        .clk(clk), .reset_n(reset_n), .start(start), .key(key32), .rk(if32.master),
        .busy(busy32), .done(done32), .rd_addr(rd_addr32), .rd_data(rd_data32)
    );

    simon_key_sched #(.WORD_W(24), .KEY_WORDS(3), .ROUNDS(36), .Z_SEQ(1)) dut24 (
        .clk(clk), .reset_n(reset_n), .start(start), .key(key24), .rk(if24.master),
        .busy(busy24), .done(done24), .rd_addr(rd_addr24), .rd_data(rd_data24)
    );

    int          sel;
    logic        obs_valid, obs_last, obs_busy, obs_done;
    logic [63:0] obs_key, obs_idx;

    always_comb begin
        obs_valid = 1'b0;
        obs_last  = 1'b0;
        obs_busy  = 1'b0;
        obs_done  = 1'b0;
        obs_key   = '0;
        obs_idx   = '0;
        case (sel)
            0: begin
                obs_valid = if16.rk_valid; obs_last = if16.rk_last; obs_busy = busy16;
                obs_done  = done16; obs_key = 64'(if16.round_key); obs_idx = 64'(if16.rk_index);
            end
            1: begin
                obs_valid = if32.rk_valid; obs_last = if32.rk_last; obs_busy = busy32;
                obs_done  = done32; obs_key = 64'(if32.round_key); obs_idx = 64'(if32.rk_index);
            end
            default: begin
                obs_valid = if24.rk_valid; obs_last = if24.rk_last; obs_busy = busy24;
                obs_done  = done24; obs_key = 64'(if24.round_key); obs_idx = 64'(if24.rk_index);
            end
        endcase
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    localparam logic [15:0] HAND16 [8] = '{
        16'h0100, 16'h0908, 16'h1110, 16'h1918, 16'h71C3, 16'hB649, 16'h56D4, 16'hE070
    };

    string zstr [5] = '{
        "11111010001001010110000111001101111101000100101011000011100110",
        "10001110111110010011000010110101000111011111001001100001011010",
        "10101111011100000011010010011000101000010001111110010110110011",
        "11011011101011000110010111100000010010001010011100110100001111",
        "11010001111001101011011000100000010111000011001010010011101111"
    };

    logic [63:0] ref_ks [72];
    bit          use_hand;

    function automatic logic [63:0] msk(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int w);
        return ((x >> r) | (x << (w - r))) & msk(w);
    endfunction

    task automatic gen_ref(input int w, input int m, input int zs, input logic [255:0] k);
        logic [63:0] tmp;
        logic [63:0] zb;
        for (int i = 0; i < 72; i++) begin
            if (i < m) begin
                ref_ks[i] = 64'(k >> (i * w)) & msk(w);
            end else begin
                tmp = ror(ref_ks[i-1], 3, w);
                if (m == 4) tmp = tmp ^ ref_ks[i-3];
                zb  = (zstr[zs].getc((i - m) % 62) == 8'h31) ? 64'd1 : 64'd0;
                ref_ks[i] = (~64'd3 & msk(w)) ^ zb ^ ref_ks[i-m] ^ tmp ^ ror(tmp, 1, w);
            end
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Observes the selected instance each cycle until n keys are accepted.
    task automatic stream(input int n, input bit rand_rdy);
        int cnt = 0;
        int cyc = 0;
        logic [63:0] exp;
        while (cnt < n && cyc < 2000) begin
            exp = (use_hand && cnt < 8) ? 64'(HAND16[cnt]) : ref_ks[cnt];
            chk($sformatf("valid[%0d]", cnt), 64'(obs_valid), 64'd1);
            chk($sformatf("key[%0d]", cnt), obs_key, exp);
            chk($sformatf("index[%0d]", cnt), obs_idx, 64'(cnt));
            chk($sformatf("last[%0d]", cnt), 64'(obs_last), 64'(cnt == n - 1));
            chk($sformatf("busy[%0d]", cnt), 64'(obs_busy), 64'd1);
            rk_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            if (rk_ready) cnt++;
            cyc++;
        end
        if (cnt < n) chk("stream_timeout", 64'(cnt), 64'(n));
        chk("done_after", 64'(obs_done), 64'd1);
        chk("busy_after", 64'(obs_busy), 64'd0);
        chk("valid_after", 64'(obs_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        rk_ready  = 1'b0;
        sel       = 0;
        use_hand  = 1'b1;
        key16     = 64'h1918_1110_0908_0100;
        key32     = 128'h1b1a1918_13121110_0b0a0908_03020100;
        key24     = 72'h121110_0a0908_020100;
        rd_addr16 = '0;
        rd_addr32 = '0;
        rd_addr24 = '0;

        #3;
        chk("rst_valid", 64'(if16.rk_valid), 64'd0);
        chk("rst_busy", 64'(busy16), 64'd0);
        chk("rst_done", 64'(done16), 64'd0);
        chk("rst_key", 64'(if16.round_key), 64'd0);
        chk("rst_index", 64'(if16.rk_index), 64'd0);
        chk("rst_rd_data", 64'(rd_data16), 64'd0);
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Full stream with the published 32/64 key, ready held high.
        gen_ref(16, 4, 0, 256'(key16));
        do_start();
        stream(32, 1'b0);

        // Same sequence under random back-pressure.
        do_start();
        stream(32, 1'b1);

        // Restart at i=10 with a new key, start coinciding with a handshake.
        do_start();
        rk_ready = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        chk("pre_restart_index", obs_idx, 64'd10);
        chk("pre_restart_key", obs_key, ref_ks[10]);
        key16 = 64'h0123_4567_89ab_cdef;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("restart_index", obs_idx, 64'd0);
        chk("restart_key0", obs_key, 64'hcdef);
        chk("restart_done", 64'(obs_done), 64'd0);
        use_hand = 1'b0;
        gen_ref(16, 4, 0, 256'(key16));
        stream(32, 1'b0);

        // Asynchronous reset in the middle of a run.
        key16    = 64'h1918_1110_0908_0100;
        use_hand = 1'b1;
        gen_ref(16, 4, 0, 256'(key16));
        do_start();
        rk_ready = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        chk("pre_reset_index", obs_idx, 64'd5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 64'(if16.rk_valid), 64'd0);
        chk("arst_busy", 64'(busy16), 64'd0);
        chk("arst_done", 64'(done16), 64'd0);
        chk("arst_rd_data", 64'(rd_data16), 64'd0);
        chk("arst_index", 64'(if16.rk_index), 64'd0);
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", 64'(if16.rk_valid), 64'd0);
        do_start();
        stream(32, 1'b0);

        // 64/128 geometry with z3; index 43 goes past the 62-entry z wrap? no, but exercises late z bits.
        sel      = 1;
        use_hand = 1'b0;
        gen_ref(32, 4, 3, 256'(key32));
        do_start();
        stream(44, 1'b0);
`ifdef SIMON_KS_STORE_EN
        for (int a = 0; a < 44; a++) begin
            rd_addr32 = 6'(a);
            @(posedge clk); #1;
            chk($sformatf("rd_data32[%0d]", a), 64'(rd_data32), ref_ks[a]);
        end
`else
        rd_addr32 = 6'd43;
        @(posedge clk); #1;
        chk("rd_data32_tied", 64'(rd_data32), 64'd0);
`endif

        // Three-word schedule, 48/72 geometry, random back-pressure.
        sel = 2;
        gen_ref(24, 3, 1, 256'(key24));
        do_start();
        stream(36, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
